// File: rtl/elbeth_pipe_pkg.sv
// Shared state encodings and default widths for the ELBETH pipeline stage register.
// The state encodings double as the occupancy count, so keep them in sync with that meaning.
package elbeth_pipe_pkg;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam int DEF_INST_WIDTH = 32;
    localparam int DEF_PC_WIDTH   = 32;
    localparam int DEF_EXC_WIDTH  = 4;
    localparam int DEF_PERF_WIDTH = 16;

    localparam logic [DEF_INST_WIDTH-1:0] DEF_BUBBLE_INST = '0;
endpackage

// File: rtl/elbeth_pipe_payload_reg.sv
// One {instruction, pc, except_source} entry: 1-cycle load, clear wins over load.
// No handshake of its own; the owning stage decides when to load or clear.
module elbeth_pipe_payload_reg
    import elbeth_pipe_pkg::*;
#(
    parameter int                    INST_WIDTH  = DEF_INST_WIDTH,
    parameter int                    PC_WIDTH    = DEF_PC_WIDTH,
    parameter int                    EXC_WIDTH   = DEF_EXC_WIDTH,
    parameter logic [INST_WIDTH-1:0] BUBBLE_INST = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld,
    input  logic                  clr,
    input  logic [INST_WIDTH-1:0] in_instruction,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [EXC_WIDTH-1:0]  in_except_source,
    output logic [INST_WIDTH-1:0] out_instruction,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [EXC_WIDTH-1:0]  out_except_source
);
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [EXC_WIDTH-1:0]  exc_q, exc_d;

    always_comb begin
        inst_d = inst_q;
        pc_d   = pc_q;
        exc_d  = exc_q;
        if (clr) begin
            inst_d = BUBBLE_INST;
            pc_d   = '0;
            exc_d  = '0;
        end else if (ld) begin
            inst_d = in_instruction;
            pc_d   = in_pc;
            exc_d  = in_except_source;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q <= '0;
            pc_q   <= '0;
            exc_q  <= '0;
        end else begin
            inst_q <= inst_d;
            pc_q   <= pc_d;
            exc_q  <= exc_d;
        end
    end

    assign out_instruction   = inst_q;
    assign out_pc            = pc_q;
    assign out_except_source = exc_q;
endmodule

// File: rtl/elbeth_pipe_stage_register.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer; 1-cycle accept-to-output.
// With SKID_EN in_ready is registered (low only when both entries are held); without it in_ready is combinational.
module elbeth_pipe_stage_register
    import elbeth_pipe_pkg::*;
#(
    parameter int                    INST_WIDTH  = DEF_INST_WIDTH,
    parameter int                    PC_WIDTH    = DEF_PC_WIDTH,
    parameter int                    EXC_WIDTH   = DEF_EXC_WIDTH,
    parameter bit                    SKID_EN     = 1'b1,
    parameter logic [INST_WIDTH-1:0] BUBBLE_INST = INST_WIDTH'(DEF_BUBBLE_INST),
    parameter int                    PERF_WIDTH  = DEF_PERF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] in_instruction,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [EXC_WIDTH-1:0]  in_except_source,
    input  logic                  ctrl_stall,
    input  logic                  ctrl_flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_instruction,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [EXC_WIDTH-1:0]  out_except_source,
    output logic [1:0]            occupancy,
    output logic [PERF_WIDTH-1:0] perf_bubbles
);
    logic [1:0]            state_q, state_d;
    logic [PERF_WIDTH-1:0] perf_q, perf_d;
    logic                  accept, drain;
    logic                  main_ld, main_from_skid, skid_ld;

    logic [INST_WIDTH-1:0] main_inst, skid_inst, main_src_inst;
    logic [PC_WIDTH-1:0]   main_pc, skid_pc, main_src_pc;
    logic [EXC_WIDTH-1:0]  main_exc, skid_exc, main_src_exc;

    assign out_valid = (state_q != ST_EMPTY);
    assign drain     = out_valid & out_ready & ~ctrl_stall;
    assign in_ready  = SKID_EN ? (state_q != ST_SKID)
                               : (~out_valid | (out_ready & ~ctrl_stall));
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        if (ctrl_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_ld = 1'b1;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        main_ld = 1'b1;
                    end else if (accept && SKID_EN) begin
                        skid_ld = 1'b1;
                        state_d = ST_SKID;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        perf_d = perf_q;
        if (!out_valid && !ctrl_flush && (perf_q != {PERF_WIDTH{1'b1}})) begin
            perf_d = perf_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            perf_q  <= perf_d;
        end
    end

    assign main_src_inst = main_from_skid ? skid_inst : in_instruction;
    assign main_src_pc   = main_from_skid ? skid_pc   : in_pc;
    assign main_src_exc  = main_from_skid ? skid_exc  : in_except_source;

    elbeth_pipe_payload_reg #(
        .INST_WIDTH (INST_WIDTH),
        .PC_WIDTH   (PC_WIDTH),
        .EXC_WIDTH  (EXC_WIDTH),
        .BUBBLE_INST(BUBBLE_INST)
    ) u_main (
        .clk              (clk),
        .rst              (rst),
        .ld               (main_ld),
        .clr              (ctrl_flush),
        .in_instruction   (main_src_inst),
        .in_pc            (main_src_pc),
        .in_except_source (main_src_exc),
        .out_instruction  (main_inst),
        .out_pc           (main_pc),
        .out_except_source(main_exc)
    );

    generate
        if (SKID_EN) begin : g_skid
            elbeth_pipe_payload_reg #(
                .INST_WIDTH (INST_WIDTH),
                .PC_WIDTH   (PC_WIDTH),
                .EXC_WIDTH  (EXC_WIDTH),
                .BUBBLE_INST(BUBBLE_INST)
            ) u_skid (
                .clk              (clk),
                .rst              (rst),
                .ld               (skid_ld),
                .clr              (ctrl_flush),
                .in_instruction   (in_instruction),
                .in_pc            (in_pc),
                .in_except_source (in_except_source),
                .out_instruction  (skid_inst),
                .out_pc           (skid_pc),
                .out_except_source(skid_exc)
            );
        end else begin : g_no_skid
            assign skid_inst = '0;
            assign skid_pc   = '0;
            assign skid_exc  = '0;
        end
    endgenerate

    // Main entry is only meaningful while valid; otherwise present the bubble pattern.
    assign out_instruction   = out_valid ? main_inst : BUBBLE_INST;
    assign out_pc            = out_valid ? main_pc   : '0;
    assign out_except_source = out_valid ? main_exc  : '0;
    // State encoding equals the number of held entries.
    assign occupancy         = state_q;
    assign perf_bubbles      = perf_q;
endmodule

// File: tb/tb_elbeth_pipe_stage_register.sv
// Bench: three builds (skid, no-skid, 4-bit counter) share stimulus; each is checked against a queue model.
module tb_elbeth_pipe_stage_register;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic [3:0]  in_except_source;
    logic        ctrl_stall;
    logic        ctrl_flush;
    logic        out_ready;

    logic [2:0]  ir, ov;
    logic [31:0] oi [3];
    logic [31:0] op [3];
    logic [3:0]  oe [3];
    logic [1:0]  occ [3];
    logic [15:0] pb0, pb1;
    logic [3:0]  pb2;

    int checks = 0;
    int errors = 0;

    elbeth_pipe_stage_register dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .in_instruction(in_instruction), .in_pc(in_pc), .in_except_source(in_except_source),
        .ctrl_stall(ctrl_stall), .ctrl_flush(ctrl_flush), .out_valid(ov[0]), .out_ready(out_ready),
        .out_instruction(oi[0]), .out_pc(op[0]), .out_except_source(oe[0]),
        .occupancy(occ[0]), .perf_bubbles(pb0)
    );

    elbeth_pipe_stage_register #(.SKID_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .in_instruction(in_instruction), .in_pc(in_pc), .in_except_source(in_except_source),
        .ctrl_stall(ctrl_stall), .ctrl_flush(ctrl_flush), .out_valid(ov[1]), .out_ready(out_ready),
        .out_instruction(oi[1]), .out_pc(op[1]), .out_except_source(oe[1]),
        .occupancy(occ[1]), .perf_bubbles(pb1)
    );

    elbeth_pipe_stage_register #(.PERF_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .in_instruction(in_instruction), .in_pc(in_pc), .in_except_source(in_except_source),
        .ctrl_stall(ctrl_stall), .ctrl_flush(ctrl_flush), .out_valid(ov[2]), .out_ready(out_ready),
        .out_instruction(oi[2]), .out_pc(op[2]), .out_except_source(oe[2]),
        .occupancy(occ[2]), .perf_bubbles(pb2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference model: per build, an ordered list of held entries (capacity 2 with skid, 1 without).
    int          cnt_m  [3];
    int          perf_m [3];
    logic [31:0] mi [3][2];
    logic [31:0] mp [3][2];
    logic [3:0]  me [3][2];
    bit          mdl_on = 1'b0;

    function automatic bit has_skid(int i);
        return i != 1;
    endfunction

    function automatic int perf_max(int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    function automatic bit exp_ir(int i);
        if (has_skid(i)) return cnt_m[i] < 2;
        return (cnt_m[i] == 0) || (out_ready && !ctrl_stall);
    endfunction

    always @(posedge clk) begin : mdl
        bit inr, drn, acc;
        for (int i = 0; i < 3; i++) begin
            inr = exp_ir(i);
            if (rst) begin
                cnt_m[i]  = 0;
                perf_m[i] = 0;
            end else if (ctrl_flush) begin
                cnt_m[i] = 0;
            end else begin
                if (cnt_m[i] == 0 && perf_m[i] < perf_max(i)) perf_m[i]++;
                drn = (cnt_m[i] > 0) && out_ready && !ctrl_stall;
                acc = in_valid && inr;
                if (drn) begin
                    mi[i][0] = mi[i][1];
                    mp[i][0] = mp[i][1];
                    me[i][0] = me[i][1];
                    cnt_m[i]--;
                end
                if (acc) begin
                    mi[i][cnt_m[i]] = in_instruction;
                    mp[i][cnt_m[i]] = in_pc;
                    me[i][cnt_m[i]] = in_except_source;
                    cnt_m[i]++;
                end
            end
        end
        if (rst) mdl_on = 1'b1;
    end

    always @(negedge clk) begin : cmp
        logic        v;
        logic [15:0] pb;
        if (mdl_on) begin
            for (int i = 0; i < 3; i++) begin
                v  = (cnt_m[i] > 0);
                pb = (i == 0) ? pb0 : (i == 1) ? pb1 : {12'd0, pb2};
                chk($sformatf("d%0d_in_ready", i), 64'(ir[i]), 64'(exp_ir(i)));
                chk($sformatf("d%0d_out_valid", i), 64'(ov[i]), 64'(v));
                chk($sformatf("d%0d_out_inst", i), 64'(oi[i]), v ? 64'(mi[i][0]) : 64'd0);
                chk($sformatf("d%0d_out_pc", i), 64'(op[i]), v ? 64'(mp[i][0]) : 64'd0);
                chk($sformatf("d%0d_out_exc", i), 64'(oe[i]), v ? 64'(me[i][0]) : 64'd0);
                chk($sformatf("d%0d_occupancy", i), 64'(occ[i]), 64'(cnt_m[i]));
                chk($sformatf("d%0d_perf", i), 64'(pb), 64'(perf_m[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc);
        in_valid         = v;
        in_instruction   = inst;
        in_pc            = pc;
        in_except_source = pc[5:2];
    endtask

    initial begin
        logic [15:0] p0;
        rst = 1'b1;
        ctrl_stall = 1'b0;
        ctrl_flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'hABCD0000, 32'h100);

        // Reset with in_valid held high
        step();
        step();
        chk("lit_rst_out_valid", 64'(ov[0]), 64'd0);
        chk("lit_rst_out_inst", 64'(oi[0]), 64'd0);
        chk("lit_rst_occupancy", 64'(occ[0]), 64'd0);
        chk("lit_rst_in_ready", 64'(ir[0]), 64'd1);
        chk("lit_rst_perf", 64'(pb0), 64'd0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();

        // Back-to-back streaming
        p0 = '0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h1000 + 32'(4 * k), 32'(4 * k));
            step();
            chk("lit_stream_valid", 64'(ov[0]), 64'd1);
            chk("lit_stream_pc", 64'(op[0]), 64'(4 * k));
            if (k == 0) p0 = pb0;
        end
        chk("lit_stream_perf", 64'(pb0), 64'(p0));
        drive(1'b0, 32'h0, 32'h0);
        step();

        // Skid fill under stall
        ctrl_stall = 1'b1;
        drive(1'b1, 32'h11111111, 32'h40);
        step();
        chk("lit_skid_occ1", 64'(occ[0]), 64'd1);
        drive(1'b1, 32'h22222222, 32'h44);
        step();
        chk("lit_skid_occ2", 64'(occ[0]), 64'd2);
        chk("lit_skid_in_ready", 64'(ir[0]), 64'd0);
        chk("lit_skid_head", 64'(oi[0]), 64'h11111111);
        drive(1'b0, 32'h0, 32'h0);
        step();
        ctrl_stall = 1'b0;
        #1;
        chk("lit_release_head", 64'(oi[0]), 64'h11111111);
        step();
        chk("lit_release_second", 64'(oi[0]), 64'h22222222);
        chk("lit_release_occ", 64'(occ[0]), 64'd1);
        step();
        chk("lit_release_empty", 64'(ov[0]), 64'd0);

        // Flush while in SKID with stall and incoming payload
        ctrl_stall = 1'b1;
        drive(1'b1, 32'h33333333, 32'h60);
        step();
        drive(1'b1, 32'h44444444, 32'h64);
        step();
        chk("lit_flush_pre_occ", 64'(occ[0]), 64'd2);
        ctrl_flush = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 32'hDEAD0);
        step();
        chk("lit_flush_valid", 64'(ov[0]), 64'd0);
        chk("lit_flush_occ", 64'(occ[0]), 64'd0);
        chk("lit_flush_pc", 64'(op[0]), 64'd0);
        ctrl_flush = 1'b0;
        ctrl_stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lit_flush_no_ghost", 64'(ov[0]), 64'd0);
        end

        // Combinational in_ready of the no-skid build
        out_ready = 1'b0;
        drive(1'b1, 32'h55555555, 32'h500);
        step();
        drive(1'b1, 32'h66666666, 32'h504);
        #1;
        chk("lit_noskid_ready_low", 64'(ir[1]), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("lit_noskid_ready_high", 64'(ir[1]), 64'd1);
        step();
        chk("lit_noskid_reload", 64'(op[1]), 64'h504);
        drive(1'b0, 32'h0, 32'h0);
        step();

        // Counter saturation on the 4-bit build
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 14) chk("lit_sat_14", 64'(pb2), 64'd14);
            if (k == 15) chk("lit_sat_15", 64'(pb2), 64'd15);
            if (k == 20) chk("lit_sat_hold", 64'(pb2), 64'd15);
        end

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            ctrl_flush = ($urandom_range(0, 39) == 0);
            ctrl_stall = ($urandom_range(0, 3) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 2) != 0, $urandom, {$urandom_range(0, 16383), 2'b00});
            in_except_source = 4'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
